// File: rtl/audio_clk_gen_if.sv
// Configuration port bundle for audio_clk_gen.
//   cfg_valid  : requester -> block, config request (held until cfg_ready)
//   cfg_ready  : block -> requester, block can accept a config
//   cfg_sel    : requester -> block, target channel index
//   cfg_inc    : requester -> block, new phase increment for that channel
//   cfg_err    : block -> requester, one-cycle pulse on a rejected request
// master modport: requester side; slave modport: audio_clk_gen side.
interface audio_clk_gen_if #(
  parameter int NUM_CLKS = 2,
  parameter int ACC_W    = 32
);
  localparam int SEL_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_sel;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_sel, cfg_inc,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_inc,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/audio_clk_gen.sv
// Multi-channel fractional audio clock generator, single refclk domain.
// Each channel runs a phase accumulator; its MSB is the generated clock.
// A settle counter gates `locked` after reset and after every config commit.
//
// Ports:
//   refclk      : sole clock
//   rst_n       : asynchronous active-low reset
//   cfg         : audio_clk_gen_if.slave config port (valid/ready/sel/inc/err)
//   outclk      : generated clocks, one bit per channel (accumulator MSB)
//   outclk_stb  : one-cycle pulse coincident with each outclk rising edge
//   locked      : all channels stable, config port open
//
// Build option: define AUDIO_CLK_GEN_PHASE_ALIGN_EN to clear every
// accumulator on an accepted config (phase-aligned restart); by default
// only the selected channel is cleared.
module audio_clk_gen #(
  parameter int          NUM_CLKS    = 2,
  parameter int          ACC_W       = 32,
  parameter logic [31:0] INIT_INC    = 32'h5E5F_0000,
  parameter int          LOCK_CYCLES = 1024
) (
  input  logic                refclk,
  input  logic                rst_n,
  audio_clk_gen_if.slave      cfg,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_stb,
  output logic                locked
);
  localparam int unsigned      N        = NUM_CLKS;
  localparam int               CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [ACC_W-1:0] INC_RST  = INIT_INC[ACC_W-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    SETTLE,
    IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             idle;
  logic             sel_ok;
  logic             inc_ok;
  logic             accept;
  logic             reject;

  logic [ACC_W-1:0] acc     [NUM_CLKS];
  logic [ACC_W-1:0] inc     [NUM_CLKS];
  logic [ACC_W-1:0] acc_nxt [NUM_CLKS];
  logic [N-1:0]     sel_hit;
  logic [N-1:0]     clr;

  // Request decode. Increments at or above half scale would alias past
  // Nyquist, so they are refused along with out-of-range channel indices.
  always_comb begin
    idle   = (state == IDLE);
    sel_ok = (32'(cfg.cfg_sel) < 32'(NUM_CLKS));
    inc_ok = ~cfg.cfg_inc[ACC_W-1];
    accept = cfg.cfg_valid & idle & sel_ok & inc_ok;
    reject = cfg.cfg_valid & idle & ~(sel_ok & inc_ok);
  end

  // Settle/lock FSM
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    locked        = 1'b0;
    cfg.cfg_ready = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        locked        = 1'b1;
        cfg.cfg_ready = 1'b1;
        if (accept) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= reject;
    end
  end

  // Channel datapath
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      sel_hit[i] = accept && (32'(cfg.cfg_sel) == i);
`ifdef AUDIO_CLK_GEN_PHASE_ALIGN_EN
      clr[i]     = accept;
`else
      clr[i]     = sel_hit[i];
`endif
      // inc == 0 naturally holds the accumulator, so halt needs no special case
      acc_nxt[i] = clr[i] ? '0 : acc[i] + inc[i];
      outclk[i]  = acc[i][ACC_W-1];
    end
  end

  // Strobe is derived from the same next-state value that loads acc, so it
  // lands in the same cycle as the outclk rise rather than one cycle later.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_RST;
      end
      outclk_stb <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        acc[i]        <= acc_nxt[i];
        outclk_stb[i] <= ~acc[i][ACC_W-1] & acc_nxt[i][ACC_W-1];
        if (sel_hit[i]) begin
          inc[i] <= cfg.cfg_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed self-checking bench for audio_clk_gen (ACC_W=8, NUM_CLKS=2,
// LOCK_CYCLES=16, INIT_INC=64), plus a 3-channel instance for the
// out-of-range channel select case that a 1-bit cfg_sel cannot express.
module tb_audio_clk_gen;
  logic refclk = 1'b0;
  logic rst_n;
  always #5 refclk = ~refclk;

  audio_clk_gen_if #(.NUM_CLKS(2), .ACC_W(8)) cfg_if ();
  logic [1:0] outclk, outclk_stb;
  logic       locked;

  audio_clk_gen #(
    .NUM_CLKS(2), .ACC_W(8), .INIT_INC(32'd64), .LOCK_CYCLES(16)
  ) u_dut (
    .refclk(refclk), .rst_n(rst_n), .cfg(cfg_if),
    .outclk(outclk), .outclk_stb(outclk_stb), .locked(locked)
  );

  audio_clk_gen_if #(.NUM_CLKS(3), .ACC_W(8)) cfg3_if ();
  logic [2:0] outclk3, outclk_stb3;
  logic       locked3;

  audio_clk_gen #(
    .NUM_CLKS(3), .ACC_W(8), .INIT_INC(32'd64), .LOCK_CYCLES(4)
  ) u_dut3 (
    .refclk(refclk), .rst_n(rst_n), .cfg(cfg3_if),
    .outclk(outclk3), .outclk_stb(outclk_stb3), .locked(locked3)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n;
  int a0, a1, inc0, inc1;

  // Closed-form channel model: phase = (edges since last clear) * inc mod 256
  function automatic logic mclk(input int ch, input int n);
    int a, s;
    a = (ch == 0) ? a0 : a1;
    s = (ch == 0) ? inc0 : inc1;
    return (((n - a) * s) % 256) >= 128;
  endfunction

  function automatic logic [1:0] exp_clk(input int n);
    return {mclk(1, n), mclk(0, n)};
  endfunction

  function automatic logic [1:0] exp_stb(input int n);
    logic [1:0] r;
    r[0] = (n > a0) && mclk(0, n) && !mclk(0, n - 1);
    r[1] = (n > a1) && mclk(1, n) && !mclk(1, n - 1);
    return r;
  endfunction

  task automatic step();
    @(posedge refclk);
    #1;
    edge_n++;
  endtask

  task automatic model_accept(input int ch, input int s);
    if (ch == 0) begin a0 = edge_n; inc0 = s; end
    else begin a1 = edge_n; inc1 = s; end
`ifdef AUDIO_CLK_GEN_PHASE_ALIGN_EN
    a0 = edge_n;
    a1 = edge_n;
`endif
  endtask

  task automatic model_reset();
    edge_n = 0;
    a0 = 0; a1 = 0; inc0 = 64; inc1 = 64;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_sel = '0; cfg_if.cfg_inc = '0;
    cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_sel = '0; cfg3_if.cfg_inc = '0;
    #3;
    checks++;
    if ({locked, cfg_if.cfg_ready, cfg_if.cfg_err, outclk, outclk_stb} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {locked, cfg_if.cfg_ready, cfg_if.cfg_err, outclk, outclk_stb});
    end
    @(posedge refclk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (locked !== (k >= 16) || cfg_if.cfg_ready !== (k >= 16)) begin
        failures++;
        $display("FAIL reset_lock k=%0d got locked=%b ready=%b exp=%b",
                 k, locked, cfg_if.cfg_ready, (k >= 16));
      end
      checks++;
      if (outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL reset_clk k=%0d got clk=%b stb=%b exp clk=%b stb=%b",
                 k, outclk, outclk_stb, exp_clk(edge_n), exp_stb(edge_n));
      end
      step();
    end
  endtask

  task automatic test_config();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL cfg_pre_ready got=%b exp=1", cfg_if.cfg_ready);
    end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b1; cfg_if.cfg_inc = 8'd16;
    step();
    cfg_if.cfg_valid = 1'b0;
    model_accept(1, 16);
    for (int t = 0; t < 40; t++) begin
      checks++;
      if (locked !== (t >= 16) || cfg_if.cfg_ready !== (t >= 16)) begin
        failures++;
        $display("FAIL cfg_lock t=%0d got locked=%b ready=%b exp=%b",
                 t, locked, cfg_if.cfg_ready, (t >= 16));
      end
      checks++;
      if (outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL cfg_clk t=%0d got clk=%b stb=%b exp clk=%b stb=%b",
                 t, outclk, outclk_stb, exp_clk(edge_n), exp_stb(edge_n));
      end
      if (t == 8) begin
        checks++;
        if (outclk[1] !== 1'b1 || outclk_stb[1] !== 1'b1) begin
          failures++;
          $display("FAIL cfg_first_rise got clk1=%b stb1=%b exp 1 1", outclk[1], outclk_stb[1]);
        end
      end
      step();
    end
  endtask

  task automatic test_reject();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b1; cfg_if.cfg_inc = 8'd128;
    checks++;
    if (cfg_if.cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL rej_err_pre got=%b exp=0", cfg_if.cfg_err);
    end
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_err !== 1'b1 || locked !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL rej_inc got err=%b locked=%b ready=%b exp 1 1 1",
               cfg_if.cfg_err, locked, cfg_if.cfg_ready);
    end
    step();
    checks++;
    if (cfg_if.cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL rej_err_width got=%b exp=0", cfg_if.cfg_err);
    end
    for (int t = 0; t < 20; t++) begin
      checks++;
      if (locked !== 1'b1 || outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL rej_hold t=%0d got locked=%b clk=%b stb=%b exp 1 %b %b",
                 t, locked, outclk, outclk_stb, exp_clk(edge_n), exp_stb(edge_n));
      end
      step();
    end
    // out-of-range select on the 3-channel instance
    cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_sel = 2'd3; cfg3_if.cfg_inc = 8'd16;
    step();
    cfg3_if.cfg_valid = 1'b0;
    checks++;
    if (cfg3_if.cfg_err !== 1'b1 || locked3 !== 1'b1) begin
      failures++;
      $display("FAIL rej_sel got err=%b locked=%b exp 1 1", cfg3_if.cfg_err, locked3);
    end
    for (int t = 0; t < 6; t++) begin
      step();
      checks++;
      if (cfg3_if.cfg_err !== 1'b0 || locked3 !== 1'b1 ||
          outclk3 !== {3{((edge_n % 4) >= 2)}}) begin
        failures++;
        $display("FAIL rej_sel_hold t=%0d got err=%b locked=%b clk=%b exp 0 1 %b",
                 t, cfg3_if.cfg_err, locked3, outclk3, {3{((edge_n % 4) >= 2)}});
      end
    end
    // highest legal channel on the 3-channel instance is accepted
    cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_sel = 2'd2; cfg3_if.cfg_inc = 8'd32;
    step();
    cfg3_if.cfg_valid = 1'b0;
    checks++;
    if (cfg3_if.cfg_err !== 1'b0 || locked3 !== 1'b0 || outclk3[2] !== 1'b0) begin
      failures++;
      $display("FAIL acc_sel2 got err=%b locked=%b clk2=%b exp 0 0 0",
               cfg3_if.cfg_err, locked3, outclk3[2]);
    end
  endtask

  task automatic test_settle_hold();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b1; cfg_if.cfg_inc = 8'd32;
    step();
    model_accept(1, 32);
    cfg_if.cfg_inc = 8'd8;  // held through SETTLE
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (cfg_if.cfg_ready !== 1'b0 || locked !== 1'b0 ||
          outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL hold_settle t=%0d got ready=%b locked=%b clk=%b stb=%b exp 0 0 %b %b",
                 t, cfg_if.cfg_ready, locked, outclk, outclk_stb, exp_clk(edge_n), exp_stb(edge_n));
      end
      step();
    end
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_ready got=%b exp=1", cfg_if.cfg_ready);
    end
    step();
    cfg_if.cfg_valid = 1'b0;
    model_accept(1, 8);
    for (int t = 0; t < 21; t++) begin
      checks++;
      if (locked !== (t >= 16) || cfg_if.cfg_ready !== (t >= 16) ||
          outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL hold_commit t=%0d got locked=%b ready=%b clk=%b stb=%b exp %b %b %b",
                 t, locked, cfg_if.cfg_ready, outclk, outclk_stb,
                 (t >= 16), exp_clk(edge_n), exp_stb(edge_n));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_settle();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b0; cfg_if.cfg_inc = 8'd32;
    step();
    cfg_if.cfg_valid = 1'b0;
    model_accept(0, 32);
    for (int t = 0; t < 5; t++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, cfg_if.cfg_ready, cfg_if.cfg_err, outclk, outclk_stb} !== 7'b0) begin
      failures++;
      $display("FAIL midrst_async got=%b exp=0000000",
               {locked, cfg_if.cfg_ready, cfg_if.cfg_err, outclk, outclk_stb});
    end
    @(posedge refclk);
    #1;
    checks++;
    if ({locked, outclk, outclk_stb} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_held got=%b exp=00000", {locked, outclk, outclk_stb});
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 21; k++) begin
      checks++;
      if (locked !== (k >= 16) || outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL midrst_relock k=%0d got locked=%b clk=%b stb=%b exp %b %b %b",
                 k, locked, outclk, outclk_stb, (k >= 16), exp_clk(edge_n), exp_stb(edge_n));
      end
      step();
    end
  endtask

`ifdef AUDIO_CLK_GEN_PHASE_ALIGN_EN
  task automatic test_phase_align();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 1'b1; cfg_if.cfg_inc = 8'd32;
    step();
    cfg_if.cfg_valid = 1'b0;
    model_accept(1, 32);
    checks++;
    if (outclk !== 2'b00) begin
      failures++;
      $display("FAIL align_clear got=%b exp=00", outclk);
    end
    for (int t = 0; t < 12; t++) begin
      checks++;
      if (outclk !== exp_clk(edge_n) || outclk_stb !== exp_stb(edge_n)) begin
        failures++;
        $display("FAIL align_run t=%0d got clk=%b stb=%b exp %b %b",
                 t, outclk, outclk_stb, exp_clk(edge_n), exp_stb(edge_n));
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_config();
    test_reject();
    test_settle_hold();
    test_reset_mid_settle();
`ifdef AUDIO_CLK_GEN_PHASE_ALIGN_EN
    test_phase_align();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
